// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
//   PS/2 keyboard receiver with a show-ahead key-event FIFO.
//   The PS/2 clock is synchronized and glitch-filtered. Each falling edge of
//   the filtered clock samples ps2d. Full 11-bit frames are checked for odd
//   parity and a high stop bit, and a stall timeout aborts a frame. The E0
//   (extended) and F0 (break) prefix bytes are folded into flags on the next
//   key byte. Each key byte is pushed as one 10-bit entry {ext, brk, code}.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   ps2d/ps2c  asynchronous PS/2 data / clock lines
//   rx_en      allows new frames to start (a frame in progress always completes)
//   rd_en      pop the head entry (ignored when empty)
//   key_code   head scan code, 0 when empty
//   key_break  head entry had an F0 prefix, 0 when empty
//   key_ext    head entry had an E0 prefix, 0 when empty
//   empty/full FIFO status
//   count      number of stored entries
//   frame_err  one-cycle pulse on a parity, stop or timeout error
//   overflow   sticky: a push was dropped because the FIFO was full
//   clr_ovf    clears overflow (a drop in the same cycle wins)
module ps2_key_fifo #(
  parameter int DEPTH       = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ps2d,
  input  logic                       ps2c,
  input  logic                       rx_en,
  input  logic                       rd_en,
  output logic [7:0]                 key_code,
  output logic                       key_break,
  output logic                       key_ext,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       frame_err,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    PFX_EXT = 8'hE0;
  localparam logic [7:0]    PFX_BRK = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CHECK
  } state_t;

  // ---- Stage p0/p1: two-flop synchronizers (idle lines are high) ----
  logic r_ps2c_p0, r_ps2c_p1;
  logic r_ps2d_p0, r_ps2d_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps2c_p0 <= 1'b1;
      r_ps2c_p1 <= 1'b1;
      r_ps2d_p0 <= 1'b1;
      r_ps2d_p1 <= 1'b1;
    end else begin
      r_ps2c_p0 <= ps2c;
      r_ps2c_p1 <= r_ps2c_p0;
      r_ps2d_p0 <= ps2d;
      r_ps2d_p1 <= r_ps2d_p0;
    end
  end

  // ---- Stage p2: clock glitch filter and falling-edge tick ----
  logic [FILTER_LEN-1:0] r_filt_sr;
  logic                  r_filt_clk;
  logic                  r_filt_clk_d;
  logic                  w_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt_sr    <= '1;
      r_filt_clk   <= 1'b1;
      r_filt_clk_d <= 1'b1;
    end else begin
      r_filt_sr <= {r_filt_sr[FILTER_LEN-2:0], r_ps2c_p1};
      // Hysteresis: only a unanimous window changes the filtered level
      if (&r_filt_sr) begin
        r_filt_clk <= 1'b1;
      end else if (~|r_filt_sr) begin
        r_filt_clk <= 1'b0;
      end
      r_filt_clk_d <= r_filt_clk;
    end
  end

  assign w_tick = r_filt_clk_d & ~r_filt_clk;

  // ---- Frame FSM ----
  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_bit_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_stop;
  logic        w_in_frame;
  logic        w_timeout;
  logic        w_frame_ok;
  logic        w_byte_valid;
  logic        w_frame_err;

  assign w_in_frame = (r_state == S_DATA) || (r_state == S_PARITY) ||
                      (r_state == S_STOP);
  // A tick in the same cycle counts as progress, so it suppresses the timeout
  assign w_timeout  = w_in_frame && !w_tick && (r_to_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_tick && rx_en && !r_ps2d_p1) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick && (r_bit_cnt == 3'd7)) begin
          w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (r_state != S_DATA) begin
        r_bit_cnt <= '0;
      end else if (w_tick) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_in_frame && !w_tick && !w_timeout) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // Received bits; every frame overwrites all of them before CHECK
  always_ff @(posedge clk) begin
    if (w_tick) begin
      case (r_state)
        S_DATA:   r_shift <= {r_ps2d_p1, r_shift[7:1]};
        S_PARITY: r_par   <= r_ps2d_p1;
        S_STOP:   r_stop  <= r_ps2d_p1;
        default:  ;
      endcase
    end
  end

  assign w_frame_ok   = (^{r_shift, r_par}) & r_stop;
  assign w_byte_valid = (r_state == S_CHECK) && w_frame_ok;
  assign w_frame_err  = ((r_state == S_CHECK) && !w_frame_ok) || w_timeout;
  assign frame_err    = w_frame_err;

  // ---- Prefix decode ----
  logic       r_ext_flag;
  logic       r_brk_flag;
  logic       w_push;
  logic [9:0] w_din;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (w_frame_err) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (w_byte_valid) begin
      if (r_shift == PFX_EXT) begin
        r_ext_flag <= 1'b1;
      end else if (r_shift == PFX_BRK) begin
        r_brk_flag <= 1'b1;
      end else begin
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end
    end
  end

  assign w_push = w_byte_valid && (r_shift != PFX_EXT) && (r_shift != PFX_BRK);
  assign w_din  = {r_ext_flag, r_brk_flag, r_shift};

  // ---- Show-ahead FIFO ----
  logic [9:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic [9:0]    w_head;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = rd_en && !w_empty;
  // When full, a push only fits if a pop frees the head slot in the same cycle
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign key_code  = w_empty ? 8'h00 : w_head[7:0];
  assign key_break = w_empty ? 1'b0  : w_head[8];
  assign key_ext   = w_empty ? 1'b0  : w_head[9];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;

  localparam int DEPTH   = 8;
  localparam int FLEN    = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       rx_en = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       frame_err;
  logic       overflow;

  ps2_key_fifo #(
    .DEPTH(DEPTH),
    .FILTER_LEN(FLEN),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2d(ps2d),
    .ps2c(ps2c),
    .rx_en(rx_en),
    .rd_en(rd_en),
    .key_code(key_code),
    .key_break(key_break),
    .key_ext(key_ext),
    .empty(empty),
    .full(full),
    .count(count),
    .frame_err(frame_err),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  always @(posedge clk) begin
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: queue of {ext, brk, code} entries plus prefix flags
  logic [9:0] q[$];
  bit m_ext = 0;
  bit m_brk = 0;
  bit m_ovf = 0;
  int exp_err = 0;

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_pop();
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'h000;
    chk({tag, ":count"}, 32'(count), 32'(q.size()));
    chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ":full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ":key_code"}, 32'(key_code), 32'(h[7:0]));
    chk({tag, ":key_break"}, 32'(key_break), 32'(h[8]));
    chk({tag, ":key_ext"}, 32'(key_ext), 32'(h[9]));
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":frame_errs"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One PS/2 bit: data set while clock high, then a low phase. During the
  // low phase rd_en can be raised for exactly the edge rd_at cycles after
  // the fall, and the cycle at which empty first drops can be measured.
  task automatic send_bit(input bit b, input int rd_at, input bit meas, output int lat);
    lat = 0;
    ps2d = b;
    tick_n(HALF);
    ps2c = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      rd_en = (rd_at == i);
      tick_n(1);
      if (meas && lat == 0 && !empty) lat = i;
    end
    rd_en = 1'b0;
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int rd_at, output int lat);
    int dummy;
    logic [10:0] bits;
    bits = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i], 0, 0, dummy);
    send_bit(bits[10], rd_at, 1, lat);
    tick_n(4);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    int dummy;
    logic [10:0] bits;
    bits = {1'b1, ~(^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], 0, 0, dummy);
  endtask

  task automatic pop_pulse();
    rd_en = 1'b1;
    tick_n(1);
    rd_en = 1'b0;
    model_pop();
  endtask

  task automatic frame(input logic [7:0] b, input bit bad);
    int lat;
    send_frame(b, bad, 1'b0, 0, lat);
    model_byte(b, bad);
  endtask

  initial begin
    int lat;
    int push_lat;
    logic [7:0] b;
    bit bad;

    // Reset state
    tick_n(5);
    chk("reset:frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    tick_n(2);
    check_all("reset");

    // Make code 0x1C; measure the push latency from the stop-bit fall
    send_frame(8'h1C, 0, 0, 0, lat);
    model_byte(8'h1C, 0);
    push_lat = lat;
    chk("make:lat_in_low_phase", 32'(lat > 0 && lat < HALF), 32'h1);
    check_all("make");
    pop_pulse();
    check_all("make_pop");

    // Break and extended-break sequences
    frame(8'hF0, 0); frame(8'h1C, 0);
    frame(8'hE0, 0); frame(8'hF0, 0); frame(8'h75, 0);
    check_all("brk_ext");
    pop_pulse();
    check_all("brk_ext_pop1");
    pop_pulse();
    check_all("brk_ext_pop2");

    // Parity error, then E0 / bad stop / 0x75
    frame(8'h1C, 1);
    check_all("bad_parity");
    frame(8'hE0, 0);
    send_frame(8'h33, 0, 1, 0, lat);
    model_byte(8'h33, 1);
    frame(8'h75, 0);
    check_all("bad_stop");
    pop_pulse();
    check_all("bad_stop_pop");

    // Overflow with 9 make codes
    for (int i = 1; i <= 9; i++) frame(8'(i), 0);
    check_all("overflow");
    // 10th code pushed in the same cycle as a pop while full
    send_frame(8'h0A, 0, 0, push_lat, lat);
    model_pop();
    model_byte(8'h0A, 0);
    check_all("push_pop_full");
    for (int i = 0; i < DEPTH; i++) begin
      pop_pulse();
      check_all("drain");
    end
    clr_ovf = 1'b1;
    tick_n(1);
    clr_ovf = 1'b0;
    m_ovf = 0;
    check_all("clr_ovf");

    // Timeout mid-frame after an E0 prefix, then a clean 0x29
    frame(8'hE0, 0);
    send_partial(8'h33, 5);
    tick_n(TIMEOUT + 50);
    m_ext = 0; m_brk = 0; exp_err++;
    check_all("timeout");
    frame(8'h29, 0);
    check_all("after_timeout");

    // Reset mid-frame with an entry stored, then 0x5A
    send_partial(8'hFF, 5);
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
    tick_n(1);
    check_all("reset_mid");
    frame(8'h5A, 0);
    check_all("after_reset");
    pop_pulse();

    // Randomized frames, prefixes, errors, reads and overflow clears
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: ;
      endcase
      bad = ($urandom_range(0, 9) == 0);
      frame(b, bad);
      if ($urandom_range(0, 2) == 0) pop_pulse();
      if ($urandom_range(0, 7) == 0) begin
        clr_ovf = 1'b1;
        tick_n(1);
        clr_ovf = 1'b0;
        m_ovf = 0;
      end
      check_all("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
